// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Sequences bring-up and recovery of the VGA pixel-clock PLL from the free-running
// 50 MHz reference clock: reset hold, lock wait, lock qualification, run.
// Optional lock timeout / retry / fault handling is built when PLL_LOCK_TIMEOUT_EN
// is defined; without it WAIT_LOCK and STABILIZE wait indefinitely.
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       vga_rst_req,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABILIZE  = 3'd2,
        S_RUN        = 3'd3,
        S_FAULT      = 3'd4
    } state_t;

    // One shared counter serves both the reset hold and the lock qualification.
    localparam int CNT_MAX = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES
                                                                   : LOCK_STABLE_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    // Reject parameter values the sequencer cannot honour.
    if (RST_HOLD_CYCLES < 1 || LOCK_STABLE_CYCLES < 1) begin : g_bad_counts
        $error("RST_HOLD_CYCLES and LOCK_STABLE_CYCLES must be at least 1");
    end
    if (LOCK_TIMEOUT_CYCLES < 1 || MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_retry
        $error("LOCK_TIMEOUT_CYCLES must be >= 1 and MAX_RETRIES within 0..15");
    end

    logic             locked_meta_r;
    logic             locked_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [3:0]       retry_r;
    logic [3:0]       retry_nxt_s;
    logic             to_hit_s;
    state_t           to_state_s;
    logic [3:0]       to_retry_s;
    logic             pll_rst_r;
    logic             vga_rst_req_r;
    logic             ready_r;

    // Two-flop synchronizer for the lock indication, which is asynchronous to refclk
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            locked_meta_r <= 1'b0;
            locked_s      <= 1'b0;
        end else begin
            locked_meta_r <= pll_locked;
            locked_s      <= locked_meta_r;
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      MAX_RETRY_C = 4'(MAX_RETRIES);

    logic [TO_W-1:0] to_cnt_r;
    logic [TO_W-1:0] to_cnt_nxt_s;
    logic            fault_r;

    // Timeout decision: retry while budget remains, otherwise park in FAULT
    always_comb begin
        to_hit_s   = (to_cnt_r == TO_LAST);
        to_state_s = S_FAULT;
        to_retry_s = retry_r;
        if (retry_r < MAX_RETRY_C) begin
            to_state_s = S_RESET_HOLD;
            to_retry_s = retry_r + 4'd1;
        end else begin
            to_state_s = S_FAULT;
            to_retry_s = retry_r;
        end
    end

    // Timeout counter spans WAIT_LOCK and STABILIZE of one attempt; it saturates at
    // the terminal count so a lock drop on that cycle still times out in WAIT_LOCK
    always_comb begin
        to_cnt_nxt_s = '0;
        if ((state_r == S_WAIT_LOCK || state_r == S_STABILIZE) &&
            (state_nxt_s == S_WAIT_LOCK || state_nxt_s == S_STABILIZE)) begin
            to_cnt_nxt_s = to_hit_s ? to_cnt_r : to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_nxt_s = '0;
        end
    end

    // Timeout counter and fault flag registers
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= '0;
            fault_r  <= 1'b0;
        end else begin
            to_cnt_r <= to_cnt_nxt_s;
            fault_r  <= (state_nxt_s == S_FAULT);
        end
    end

    assign fault = fault_r;
`else
    // Without the timeout option nothing ever times out or counts retries
    always_comb begin
        to_hit_s   = 1'b0;
        to_state_s = S_RESET_HOLD;
        to_retry_s = 4'd0;
    end

    assign fault = 1'b0;
`endif

    // Next-state logic: relock_req first, then lock loss, then counter terminal counts
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        retry_nxt_s = retry_r;
        if (relock_req) begin
            state_nxt_s = S_RESET_HOLD;
            cnt_nxt_s   = '0;
            retry_nxt_s = 4'd0;
        end else begin
            case (state_r)
                S_RESET_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_nxt_s = S_WAIT_LOCK;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (to_hit_s) begin
                        state_nxt_s = to_state_s;
                        retry_nxt_s = to_retry_s;
                        cnt_nxt_s   = '0;
                    end else if (locked_s) begin
                        state_nxt_s = S_STABILIZE;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = '0;
                    end
                end
                S_STABILIZE: begin
                    // Qualification completing on the last allowed cycle still counts
                    if (!locked_s) begin
                        state_nxt_s = S_WAIT_LOCK;
                        cnt_nxt_s   = '0;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nxt_s = S_RUN;
                        cnt_nxt_s   = '0;
                        retry_nxt_s = 4'd0;
                    end else if (to_hit_s) begin
                        state_nxt_s = to_state_s;
                        retry_nxt_s = to_retry_s;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_nxt_s = S_RESET_HOLD;
                        cnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = S_RUN;
                    end
                end
`ifdef PLL_LOCK_TIMEOUT_EN
                S_FAULT: begin
                    state_nxt_s = S_FAULT;
                    cnt_nxt_s   = '0;
                end
`endif
                default: begin
                    state_nxt_s = S_RESET_HOLD;
                    cnt_nxt_s   = '0;
                    retry_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // State, counters and outputs all update on the same edge
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_RESET_HOLD;
            cnt_r         <= '0;
            retry_r       <= 4'd0;
            pll_rst_r     <= 1'b1;
            vga_rst_req_r <= 1'b1;
            ready_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            retry_r       <= retry_nxt_s;
            pll_rst_r     <= (state_nxt_s == S_RESET_HOLD) || (state_nxt_s == S_FAULT);
            vga_rst_req_r <= (state_nxt_s != S_RUN);
            ready_r       <= (state_nxt_s == S_RUN);
        end
    end

    assign pll_rst     = pll_rst_r;
    assign vga_rst_req = vga_rst_req_r;
    assign ready       = ready_r;
    assign retry_cnt   = retry_r;
    assign state       = state_r;

endmodule
